// File: rtl/arbitro_escritura_br_pkg.sv
// Shared constants and source encoding for the register-bank write-back arbiter.
package arbitro_escritura_br_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin arbiter. Bit 0 is the ALU request, bit 1 is the memory-load request.
module arbitro_rr2
  import arbitro_escritura_br_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  src_e last_grant_q;
  src_e last_grant_d;

  // On a tie the source that did not win last time gets the port.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == SRC_ALU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant[1] ? SRC_MEM : SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_ALU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/arbitro_escritura_br.sv
// Write-back arbiter and busy-register scoreboard in front of the single bank write port.
// Valid/ready: a producer holds Valid/Reg/Data until Valid && Ready is seen at a rising Clk edge.
module arbitro_escritura_br
  import arbitro_escritura_br_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Alu_Valid,
  output logic              Alu_Ready,
  input  logic [ADDR_W-1:0] Alu_Reg,
  input  logic [DATA_W-1:0] Alu_Data,
  input  logic              Mem_Valid,
  output logic              Mem_Ready,
  input  logic [ADDR_W-1:0] Mem_Reg,
  input  logic [DATA_W-1:0] Mem_Data,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Reg,
  input  logic [ADDR_W-1:0] Read_Reg1,
  input  logic [ADDR_W-1:0] Read_Reg2,
  output logic              Stall,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Data,
  output logic              RegWrite
);

  logic [1:0]        grant;
  logic              accept;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  arbitro_rr2 u_rr2 (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .req    ({Mem_Valid, Alu_Valid}),
    .accept (accept),
    .grant  (grant)
  );

  assign Alu_Ready = grant[0];
  assign Mem_Ready = grant[1];

  // A grant is only ever given to a valid request, so any grant is an accept.
  always_comb begin
    accept   = |grant;
    sel_reg  = grant[1] ? Mem_Reg  : Alu_Reg;
    sel_data = grant[1] ? Mem_Data : Alu_Data;
  end

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (accept) begin
      reg_write_d  = (sel_reg != '0);
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
    end
  end

  // Clear for the write leaving the port, then set for the new issue so a re-issue wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (Issue_Valid) begin
      busy_d[Issue_Reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign Write_Reg  = write_reg_q;
  assign Write_Data = write_data_q;
  assign Stall      = busy_q[Read_Reg1] | busy_q[Read_Reg2];

endmodule
